ahb_lite_mst: RTL

- AHB-Lite initiator (bus master) for the testbench. Drives transfers into the AHB-Lite memory/mailbox responder.
- Turns a simple valid/ready command stream into pipelined AHB-Lite SINGLE transfers. The address phase of transfer N+1 overlaps the data phase of transfer N.
- Returns one response per command, in order, carrying read data and an error flag.

---
 rtl/ahb_pkg.sv | 27 ++
 rtl/ahb_lite_mst_if.sv | 18 +
 rtl/ahb_mst_phase_reg.sv | 38 +++
 rtl/ahb_lite_mst.sv | 87 ++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and the master's command/response types shared across the slice.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_B = 3'd0;
  localparam logic [2:0] HSIZE_H = 3'd1;
  localparam logic [2:0] HSIZE_W = 3'd2;
  localparam logic [2:0] HSIZE_D = 3'd3;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam int AHB_AW = 64;
  localparam int AHB_DW = 64;
  typedef struct packed {
    logic              write;
    logic [AHB_AW-1:0] addr;
    logic [2:0]        size;
    logic [3:0]        prot;
    logic [AHB_DW-1:0] wdata;
  } ahb_req_t;
  typedef struct packed {
    logic [AHB_DW-1:0] rdata;
    logic              err;
  } ahb_rsp_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERR2} mst_state_t;
  localparam ahb_req_t REQ_RST = '{write: 1'b0, addr: '0, size: HSIZE_B, prot: 4'b0011, wdata: '0};
endpackage

// File: rtl/ahb_lite_mst_if.sv
// ahb_lite_mst_if: AHB-Lite bus between one master and one responder.
interface ahb_lite_mst_if #(parameter int AW = 64, parameter int DW = 64);
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic          HMASTLOCK;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic          HRESP;
  logic [DW-1:0] HRDATA;
  modport master (output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
                  input HREADY, HRESP, HRDATA);
  modport slave (input HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
                 output HREADY, HRESP, HRDATA);
endinterface

// File: rtl/ahb_mst_phase_reg.sv
// ahb_mst_phase_reg: address-phase register; holds while HREADY is low and parks a command
// cancelled by a two-cycle error response until it can be re-driven.
module ahb_mst_phase_reg
  import ahb_pkg::*;
(
  input  logic     HCLK,
  input  logic     HRESETn,
  input  logic     load,
  input  ahb_req_t req,
  input  logic     hready,
  input  logic     cancel,
  input  logic     reissue,
  input  logic     flush,
  output logic     valid,
  output logic     parked,
  output ahb_req_t aph
);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      valid  <= 1'b0;
      parked <= 1'b0;
      aph    <= REQ_RST;
    end else if (flush) begin
      valid  <= 1'b0;
      parked <= 1'b0;
    end else if (cancel) begin
      parked <= valid;
      valid  <= 1'b0;
    end else if (reissue) begin
      valid  <= parked;
      parked <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      aph   <= req;
    end else if (hready) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/ahb_lite_mst.sv
// ahb_lite_mst: AHB-Lite master turning a valid/ready command stream into pipelined SINGLE transfers.
// Define AHB_MST_TIMEOUT_EN to abort data phases stalled for TIMEOUT_CYC wait states.
module ahb_lite_mst
  import ahb_pkg::*;
#(
  parameter int AW          = 64,
  parameter int DW          = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [2:0]    req_size,
  input  logic [3:0]    req_prot,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  ahb_lite_mst_if.master bus
);
  mst_state_t state, state_nxt;
  ahb_req_t req, aph;
  logic aph_valid, parked, dph_valid, dph_write, flush_rsp;
  logic accept, cancel, reissue, tmo, dph_done, aph_done, err_wait;
  assign accept   = req_valid & req_ready;
  assign aph_done = aph_valid & bus.HREADY;
  assign dph_done = dph_valid & bus.HREADY;
  assign err_wait = dph_valid & bus.HRESP & ~bus.HREADY;
  assign req = '{write: req_write, addr: AHB_AW'(req_addr), size: req_size, prot: req_prot,
                 wdata: AHB_DW'(req_wdata)};
  ahb_mst_phase_reg u_aph (
    .HCLK(HCLK), .HRESETn(HRESETn), .load(accept), .req(req), .hready(bus.HREADY),
    .cancel(cancel), .reissue(reissue), .flush(tmo), .valid(aph_valid), .parked(parked), .aph(aph)
  );
  assign bus.HADDR     = aph.addr[AW-1:0];
  assign bus.HTRANS    = aph_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HWRITE    = aph.write;
  assign bus.HSIZE     = aph.size;
  assign bus.HPROT     = aph.prot;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HMASTLOCK = 1'b0;
`ifdef AHB_MST_TIMEOUT_EN
  logic [15:0] wait_cnt;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) wait_cnt <= '0;
    else if (bus.HREADY || tmo) wait_cnt <= '0;
    else if (dph_valid) wait_cnt <= wait_cnt + 16'd1;
  assign tmo = dph_valid & ~bus.HREADY & (wait_cnt == 16'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = tmo ? ST_RUN :
                (state == ST_IDLE) ? ST_RUN :
                (state == ST_RUN && err_wait) ? ST_ERR2 :
                (state == ST_ERR2 && bus.HREADY) ? ST_RUN : state;
  always_comb begin
    cancel    = (state == ST_RUN) & err_wait & ~tmo;
    reissue   = (state == ST_ERR2) & bus.HREADY;
    req_ready = (~aph_valid | bus.HREADY) & (state == ST_RUN) & ~(dph_valid & bus.HRESP) & ~tmo;
  end
  // a flushed address phase owes its own error response, issued the cycle after the timeout one
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      dph_valid  <= 1'b0;
      dph_write  <= 1'b0;
      flush_rsp  <= 1'b0;
      bus.HWDATA <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      dph_valid <= ~tmo & (aph_done | (dph_valid & ~bus.HREADY));
      if (aph_done) dph_write <= aph.write;
      if (aph_done && aph.write) bus.HWDATA <= aph.wdata[DW-1:0];
      flush_rsp <= tmo & (aph_valid | parked);
      rsp_valid <= dph_done | tmo | flush_rsp;
      rsp_rdata <= (dph_done && !dph_write) ? bus.HRDATA : '0;
      rsp_err   <= dph_done ? bus.HRESP : (tmo | flush_rsp);
    end
endmodule
